pp_error_monitor: RTL and testbench

- Consumer end of the partial-product reduction tree for the configurable approximate multiplier.
- Takes the two reduced rows (pp1, pp2) and the original operands through a valid/ready handshake.
- Forms the approximate product pp1 + (pp2<<1) and the exact product a*b, then accumulates error statistics over a programmed sample count.
- Results feed the compressor-configuration exploration flow as error count, summed absolute error and maximum absolute error.

---
 rtl/pp_error_monitor.sv | 222 ++++++++++++++++++++++
 tb/tb_pp_error_monitor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_error_monitor.sv
// pp_error_monitor
//   Consumer end of the partial-product reduction tree of the configurable
//   approximate multiplier. Each accepted sample carries the two reduced rows
//   (pp1 = sum row, pp2 = carry row of weight 2) and the original operands.
//   The block forms approx = pp1 + (pp2 << 1) and exact = op_a * op_b, and
//   accumulates error statistics over a programmed number of samples.
//
// Optional feature: define PP_ERR_SQUARED_EN to add the sum_sq_err output
//   (saturating sum of squared absolute errors).
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse: latch num_samples, clear stats, run
//   num_samples         samples per run (sampled only on an accepted start)
//   in_valid/in_ready   sample handshake (see below)
//   pp1, pp2            reduced rows, P = 2*Bitwidth bits
//   op_a, op_b          unsigned operands that produced pp1/pp2
//   prod_valid, prod    approximate product, one cycle per accepted sample
//   err_count           samples with approx != exact (wraps)
//   sum_abs_err         saturating sum of |approx - exact|
//   max_abs_err         largest |approx - exact| of the run
//   sum_sq_err          (PP_ERR_SQUARED_EN only) saturating sum of d*d
//   busy, done          busy in RUN/DRAIN, done in DONE
//   o_dbg_state         current FSM state encoding
//
// Handshake: a sample transfers on a rising edge where in_valid && in_ready.
//   in_ready is a function of state only (never of in_valid). While
//   in_valid=1 and in_ready=0 the sender keeps pp1/pp2/op_a/op_b stable.
//
// Timing: accepted at edge t -> prod at t+1 -> statistics at t+2.
module pp_error_monitor #(
  parameter int Bitwidth = 8,
  parameter int CNT_W    = 16,
  parameter int ACC_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_samples,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*Bitwidth-1:0] pp1,
  input  logic [2*Bitwidth-1:0] pp2,
  input  logic [Bitwidth-1:0]   op_a,
  input  logic [Bitwidth-1:0]   op_b,
  output logic                  prod_valid,
  output logic [2*Bitwidth-1:0] prod,
  output logic [CNT_W-1:0]      err_count,
  output logic [ACC_W-1:0]      sum_abs_err,
  output logic [2*Bitwidth-1:0] max_abs_err,
`ifdef PP_ERR_SQUARED_EN
  output logic [2*ACC_W-1:0]    sum_sq_err,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            o_dbg_state
);

  localparam int P = 2 * Bitwidth;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_num;
  logic [CNT_W-1:0]   r_accepted;

  logic               r_s1_valid;
  logic [P-1:0]       r_approx;
  logic [P-1:0]       r_exact;

  logic [CNT_W-1:0]   r_err_count;
  logic [ACC_W-1:0]   r_sum_abs;
  logic [P-1:0]       r_max_abs;

  logic               w_accept;
  logic               w_start_ok;
  logic [P-1:0]       w_approx;
  logic [P-1:0]       w_exact;
  logic [P-1:0]       w_diff;
  logic [ACC_W:0]     w_sum_ext;

  // ---------------------------------------------------------------------------
  // Handshake and stage-1 arithmetic
  // ---------------------------------------------------------------------------
  assign in_ready   = (r_state == ST_RUN) && (r_accepted < r_num);
  assign w_accept   = in_valid && in_ready;
  // A start is honoured only when no run is active.
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Both products are taken mod 2^P by the P-bit result width.
  assign w_approx = pp1 + (pp2 << 1);
  assign w_exact  = P'(op_a) * P'(op_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_approx   <= '0;
      r_exact    <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_approx <= w_approx;
        r_exact  <= w_exact;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: error statistics
  // ---------------------------------------------------------------------------
  assign w_diff    = (r_approx >= r_exact) ? (r_approx - r_exact)
                                           : (r_exact - r_approx);
  // One extra bit catches the carry used for saturation.
  assign w_sum_ext = {1'b0, r_sum_abs} + (ACC_W+1)'(w_diff);

`ifdef PP_ERR_SQUARED_EN
  logic [2*ACC_W-1:0] r_sum_sq;
  logic [2*P-1:0]     w_dsq;
  logic [2*ACC_W:0]   w_sq_ext;

  assign w_dsq    = (2*P)'(w_diff) * (2*P)'(w_diff);
  assign w_sq_ext = {1'b0, r_sum_sq} + (2*ACC_W+1)'(w_dsq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_sq <= '0;
    end else if (w_start_ok) begin
      r_sum_sq <= '0;
    end else if (r_s1_valid) begin
      r_sum_sq <= w_sq_ext[2*ACC_W] ? '1 : w_sq_ext[2*ACC_W-1:0];
    end
  end

  assign sum_sq_err = r_sum_sq;
`endif

  // Start only happens in IDLE/DONE, where stage 1 is always empty, so the
  // clear never races with a pending update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
      r_sum_abs   <= '0;
      r_max_abs   <= '0;
    end else if (w_start_ok) begin
      r_err_count <= '0;
      r_sum_abs   <= '0;
      r_max_abs   <= '0;
    end else if (r_s1_valid) begin
      if (w_diff != '0) begin
        r_err_count <= r_err_count + CNT_W'(1);
      end
      r_sum_abs <= w_sum_ext[ACC_W] ? '1 : w_sum_ext[ACC_W-1:0];
      if (w_diff > r_max_abs) begin
        r_max_abs <= w_diff;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Run control FSM (busy/done registered alongside the state)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_num      <= '0;
      r_accepted <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state    <= ST_RUN;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_num      <= num_samples;
            r_accepted <= '0;
          end
        end
        ST_RUN: begin
          // Limit reached (also covers num_samples == 0 on the first cycle).
          if (r_accepted == r_num) begin
            r_state <= ST_DRAIN;
          end else if (w_accept) begin
            r_accepted <= r_accepted + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          // Stage 2 writes the statistics on the same edge that stage 1
          // empties, so an empty stage 1 means the stats are final.
          if (!r_s1_valid) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign prod_valid  = r_s1_valid;
  assign prod        = r_approx;
  assign err_count   = r_err_count;
  assign sum_abs_err = r_sum_abs;
  assign max_abs_err = r_max_abs;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pp_error_monitor.sv
// Directed bench for pp_error_monitor. A second instance with ACC_W = P = 16
// shares all inputs and is checked in the saturation section.
module tb_pp_error_monitor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num_samples;
  logic        in_valid;
  logic [15:0] pp1;
  logic [15:0] pp2;
  logic [7:0]  op_a;
  logic [7:0]  op_b;

  logic        in_ready, prod_valid, busy, done;
  logic [15:0] prod, err_count, max_abs_err;
  logic [31:0] sum_abs_err;
  logic [1:0]  dbg_state;

  logic        s_in_ready, s_prod_valid, s_busy, s_done;
  logic [15:0] s_prod, s_err_count, s_max_abs_err, s_sum_abs_err;
  logic [1:0]  s_dbg_state;

`ifdef PP_ERR_SQUARED_EN
  logic [63:0] sum_sq_err;
  logic [31:0] s_sum_sq_err;
`endif

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  pp_error_monitor #(.Bitwidth(8), .CNT_W(16), .ACC_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .pp1(pp1), .pp2(pp2),
    .op_a(op_a), .op_b(op_b), .prod_valid(prod_valid), .prod(prod),
    .err_count(err_count), .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err),
`ifdef PP_ERR_SQUARED_EN
    .sum_sq_err(sum_sq_err),
`endif
    .busy(busy), .done(done), .o_dbg_state(dbg_state)
  );

  pp_error_monitor #(.Bitwidth(8), .CNT_W(16), .ACC_W(16)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(s_in_ready), .pp1(pp1), .pp2(pp2),
    .op_a(op_a), .op_b(op_b), .prod_valid(s_prod_valid), .prod(s_prod),
    .err_count(s_err_count), .sum_abs_err(s_sum_abs_err),
    .max_abs_err(s_max_abs_err),
`ifdef PP_ERR_SQUARED_EN
    .sum_sq_err(s_sum_sq_err),
`endif
    .busy(s_busy), .done(s_done), .o_dbg_state(s_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks: called #1 after a rising edge, return #1 after a rising edge.
  task automatic do_start(input logic [15:0] n);
    start       = 1'b1;
    num_samples = n;
    @(posedge clk); #1;
    start       = 1'b0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] p1, input logic [15:0] p2);
    int waitc = 0;
    logic [15:0] e;
    op_a = a; op_b = b; pp1 = p1; pp2 = p2;
    in_valid = 1'b1;
    while (!in_ready && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      e = p1 + (p2 << 1);
      exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("prod_valid", 64'(prod_valid), 64'd1);
      chk("prod", 64'(prod), 64'(exp_q.pop_front()));
    end
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic chk_stats(input string tag, input logic [15:0] e_cnt,
                           input logic [31:0] e_sum, input logic [15:0] e_max);
    chk({tag, "_err_count"}, 64'(err_count), 64'(e_cnt));
    chk({tag, "_sum_abs"}, 64'(sum_abs_err), 64'(e_sum));
    chk({tag, "_max_abs"}, 64'(max_abs_err), 64'(e_max));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_prod_valid"}, 64'(prod_valid), 64'd0);
    chk({tag, "_prod"}, 64'(prod), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'd0);
    chk_stats(tag, 16'd0, 32'd0, 16'd0);
`ifdef PP_ERR_SQUARED_EN
    chk({tag, "_sum_sq"}, sum_sq_err, 64'd0);
`endif
  endtask

  initial begin
    int accepted;
    int first_zero;
    logic ready_seen;

    rst_n = 1'b0; start = 1'b0; num_samples = '0; in_valid = 1'b0;
    pp1 = '0; pp2 = '0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Exact run: every approx equals exact
    do_start(16'd3);
    chk("exact_busy", 64'(busy), 64'd1);
    send(8'd3, 8'd5, 16'd15, 16'd0);
    send(8'd255, 8'd255, 16'hFE01, 16'd0);
    send(8'd0, 8'd9, 16'd0, 16'd0);
    wait_done(3, "exact_done");
    chk("exact_busy_end", 64'(busy), 64'd0);
    chk_stats("exact", 16'd0, 32'd0, 16'd0);

    // Error accumulation: d = 5 then d = 4
    do_start(16'd2);
    send(8'd3, 8'd5, 16'd20, 16'd0);
    send(8'd4, 8'd4, 16'd10, 16'd1);
    wait_done(3, "err_done");
    chk_stats("err", 16'd2, 32'd9, 16'd5);
`ifdef PP_ERR_SQUARED_EN
    chk("err_sum_sq", sum_sq_err, 64'd41);
`endif
    // Stats stay held in DONE
    repeat (3) @(posedge clk);
    #1;
    chk_stats("err_hold", 16'd2, 32'd9, 16'd5);

    // Zero samples: start clears the previous run's stats
    do_start(16'd0);
    ready_seen = 1'b0;
    begin
      int n = 0;
      while (!done && n < 3) begin
        ready_seen |= in_ready;
        @(posedge clk); #1;
        n++;
      end
    end
    chk("zero_no_ready", 64'(ready_seen), 64'd0);
    chk("zero_done", 64'(done), 64'd1);
    chk_stats("zero", 16'd0, 32'd0, 16'd0);

    // Backpressure and limit: in_valid held for 5 cycles, only 2 accepted
    do_start(16'd2);
    op_a = 8'd1; op_b = 8'd1; pp1 = 16'd1; pp2 = 16'd0;
    in_valid = 1'b1;
    accepted = 0;
    first_zero = 0;
    for (int c = 1; c <= 5; c++) begin
      if (in_ready) accepted++;
      else if (first_zero == 0) first_zero = c;
      if (c == 5) chk("bp_done_by_cycle5", 64'(done), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 64'(accepted), 64'd2);
    chk("bp_first_not_ready", 64'(first_zero), 64'd3);
    chk_stats("bp", 16'd0, 32'd0, 16'd0);

    // Saturation: three samples with d = 0xFFFF
    do_start(16'd3);
    repeat (3) send(8'd0, 8'd0, 16'hFFFF, 16'd0);
    wait_done(3, "sat_done");
    chk_stats("sat_main", 16'd3, 32'h0002_FFFD, 16'hFFFF);
    chk("sat_sum_abs", 64'(s_sum_abs_err), 64'hFFFF);
    chk("sat_max_abs", 64'(s_max_abs_err), 64'hFFFF);
    chk("sat_err_count", 64'(s_err_count), 64'd3);
    chk("sat_prod", 64'(s_prod), 64'hFFFF);
    chk("sat_prod_valid", 64'(s_prod_valid), 64'd0);
    chk("sat_in_ready", 64'(s_in_ready), 64'd0);
    chk("sat_busy", 64'(s_busy), 64'd0);
    chk("sat_done", 64'(s_done), 64'd1);
    chk("sat_state", 64'(s_dbg_state), 64'd3);
`ifdef PP_ERR_SQUARED_EN
    chk("sat_sum_sq", 64'(s_sum_sq_err), 64'hFFFF_FFFF);
`endif

    // Reset mid-run
    do_start(16'd3);
    send(8'd3, 8'd5, 16'd20, 16'd0);
    @(posedge clk); #1;
    chk("mid_err_count_before", 64'(err_count), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start(16'd1);
    send(8'd4, 8'd4, 16'd10, 16'd1);
    wait_done(3, "post_rst_done");
    chk_stats("post_rst", 16'd1, 32'd4, 16'd4);
`ifdef PP_ERR_SQUARED_EN
    chk("post_rst_sum_sq", sum_sq_err, 64'd16);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
